// File: rtl/bitty_pkg.sv
// bitty_pkg: shared types and constants for the Bitty instruction-fetch block.
`default_nettype none

package bitty_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/bitty_imem.sv
// bitty_imem: 2**AW x DW instruction RAM, one write port, one registered read port.
`default_nettype none

module bitty_imem #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write-first: a same-address write in the read cycle forwards the new word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: program memory plus PC sequencer that feeds one instruction
// at a time to the Bitty core and advances on the core's done pulse.
`default_nettype none

module bitty_fetch_unit #(
  parameter int          AW        = 8,
  parameter int          DW        = 16,
  parameter int unsigned LAST_ADDR = 2**AW - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_wdata,
  input  logic          done,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_target,
  output logic [DW-1:0] instruction,
  output logic          inst_valid,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  import bitty_pkg::*;

  localparam logic [AW-1:0] LAST_PC = AW'(LAST_ADDR);
  localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [DW-1:0] instr_q;
  logic          valid_q;
  logic          running_q;
  logic          halted_q;
  logic [15:0]   fcnt_q;

  logic          start_ok;
  logic          done_ok;
  logic          go_fetch;
  logic          to_halt;
  logic          mem_we;
  logic [DW-1:0] rdata;

  // The RAM read is launched with the transition into FETCH, addressed by the
  // next PC, so the word is ready to be captured when FETCH completes.
  always_comb begin
    start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
    done_ok  = done && (state_q == ST_ISSUE);
    pc_d     = pc_q;
    go_fetch = 1'b0;
    to_halt  = 1'b0;
    if (start_ok) begin
      pc_d     = start_addr;
      go_fetch = 1'b1;
    end else if (done_ok) begin
      if (branch_en) begin
        pc_d     = branch_target;
        go_fetch = 1'b1;
      end else if (pc_q == LAST_PC) begin
        to_halt = 1'b1;
      end else begin
        pc_d     = pc_q + PC_ONE;
        go_fetch = 1'b1;
      end
    end
  end

  assign mem_we = prog_we && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  bitty_imem #(
    .AW (AW),
    .DW (DW)
  ) u_imem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_wdata),
    .re_i    (go_fetch),
    .raddr_i (pc_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start_ok) begin
            state_q   <= ST_FETCH;
            pc_q      <= pc_d;
            fcnt_q    <= '0;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_q <= ST_ISSUE;
          instr_q <= rdata;
          valid_q <= 1'b1;
          fcnt_q  <= fcnt_q + 16'd1;
        end
        ST_ISSUE: begin
          if (done_ok) begin
            valid_q <= 1'b0;
            pc_q    <= pc_d;
            if (to_halt) begin
              state_q   <= ST_HALT;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign pc          = pc_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign fetch_count = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bitty_fetch_unit.sv
// tb_bitty_fetch_unit: directed scoreboard bench for bitty_fetch_unit (LAST_ADDR=3).
`default_nettype none

module tb_bitty_fetch_unit;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_wdata;
  logic          done;
  logic          branch_en;
  logic [AW-1:0] branch_target;
  logic [DW-1:0] instruction;
  logic          inst_valid;
  logic [AW-1:0] pc;
  logic          running;
  logic          halted;
  logic [15:0]   fetch_count;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t          sb_q[$];
  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] prog [4];

  always #5 clk = ~clk;

  bitty_fetch_unit #(
    .AW        (AW),
    .DW        (DW),
    .LAST_ADDR (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_wdata    (prog_wdata),
    .done          (done),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .instruction   (instruction),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .running       (running),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start (or done) for one edge, then wait for the issued word and
  // compare it against the scoreboard entry pushed with the stimulus.
  task automatic issue(input string tag, input bit use_start, input logic [AW-1:0] addr,
                       input bit br, input logic [AW-1:0] exp_pc, input logic [DW-1:0] exp_instr);
    int   lat;
    exp_t e;
    sb_q.push_back('{pc: exp_pc, instr: exp_instr});
    if (use_start) begin
      start      = 1'b1;
      start_addr = addr;
    end else begin
      done          = 1'b1;
      branch_en     = br;
      branch_target = addr;
    end
    tick();
    start     = 1'b0;
    done      = 1'b0;
    branch_en = 1'b0;
    prog_we   = 1'b0;
    chk({tag, ".dead"}, 32'(inst_valid), 32'd0);
    chk({tag, ".run"}, {30'd0, running, halted}, 32'd2);
    lat = 1;
    while (!inst_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'd2);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, ".pc"}, 32'(pc), 32'(e.pc));
      chk({tag, ".instr"}, 32'(instruction), 32'(e.instr));
    end else begin
      chk({tag, ".sb"}, 32'd0, 32'd1);
    end
  endtask

  task automatic finish_run(input string tag, input logic [15:0] exp_cnt, input logic [DW-1:0] last);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, ".halted"}, {30'd0, running, halted}, 32'd1);
    chk({tag, ".valid"}, 32'(inst_valid), 32'd0);
    chk({tag, ".count"}, 32'(fetch_count), 32'(exp_cnt));
    chk({tag, ".hold"}, 32'(instruction), 32'(last));
  endtask

  initial begin
    prog[0] = 16'h1234;
    prog[1] = 16'h5678;
    prog[2] = 16'h9ABC;
    prog[3] = 16'hDEF0;
    reset = 1'b0; start = 1'b0; start_addr = '0; prog_we = 1'b0; prog_addr = '0;
    prog_wdata = '0; done = 1'b0; branch_en = 1'b0; branch_target = '0;

    // Reset and idle state
    tick();
    tick();
    chk("rst.instr", 32'(instruction), 32'd0);
    chk("rst.valid", 32'(inst_valid), 32'd0);
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.flags", {30'd0, running, halted}, 32'd0);
    chk("rst.count", 32'(fetch_count), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_wdata = prog[i];
      tick();
    end
    prog_we = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("idle_done.flags", {30'd0, running, halted}, 32'd0);
    chk("idle_done.valid", 32'(inst_valid), 32'd0);

    // Sequential run to HALT
    issue("seq0", 1'b1, 8'd0, 1'b0, 8'd0, 16'h1234);
    for (int k = 1; k < 4; k++) begin
      tick(); tick(); tick();
      chk($sformatf("seq%0d.held", k), 32'(instruction), 32'(prog[k-1]));
      issue($sformatf("seq%0d", k), 1'b0, 8'd0, 1'b0, AW'(k), prog[k]);
    end
    tick(); tick(); tick();
    finish_run("seq", 16'd4, 16'hDEF0);

    // Branch past pc=2 straight to the last address
    issue("br0", 1'b1, 8'd0, 1'b0, 8'd0, 16'h1234);
    issue("br1", 1'b0, 8'd0, 1'b0, 8'd1, 16'h5678);
    issue("br3", 1'b0, 8'd3, 1'b1, 8'd3, 16'hDEF0);
    finish_run("br", 16'd3, 16'hDEF0);

    // Events that must be ignored outside their states
    start = 1'b1; start_addr = 8'd0;
    tick();
    start = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("ign_fetch_done.valid", 32'(inst_valid), 32'd1);
    chk("ign_fetch_done.pc", 32'(pc), 32'd0);
    chk("ign_fetch_done.instr", 32'(instruction), 32'h1234);
    start = 1'b1; start_addr = 8'd2;
    prog_we = 1'b1; prog_addr = 8'd2; prog_wdata = 16'hFFFF;
    tick();
    start = 1'b0; prog_we = 1'b0;
    chk("ign_issue.pc", 32'(pc), 32'd0);
    chk("ign_issue.valid", 32'(inst_valid), 32'd1);
    chk("ign_issue.count", 32'(fetch_count), 32'd1);
    issue("ign1", 1'b0, 8'd0, 1'b0, 8'd1, 16'h5678);
    issue("ign2", 1'b0, 8'd0, 1'b0, 8'd2, 16'h9ABC);

    // Reset in ISSUE at pc=2 coinciding with done
    reset = 1'b0; done = 1'b1;
    tick();
    reset = 1'b1; done = 1'b0;
    chk("midrst.flags", {30'd0, running, halted}, 32'd0);
    chk("midrst.pc", 32'(pc), 32'd0);
    chk("midrst.valid", 32'(inst_valid), 32'd0);
    chk("midrst.count", 32'(fetch_count), 32'd0);
    issue("re0", 1'b1, 8'd0, 1'b0, 8'd0, 16'h1234);
    issue("re1", 1'b0, 8'd0, 1'b0, 8'd1, 16'h5678);
    issue("re2", 1'b0, 8'd0, 1'b0, 8'd2, 16'h9ABC);
    issue("re3", 1'b0, 8'd0, 1'b0, 8'd3, 16'hDEF0);
    finish_run("re", 16'd4, 16'hDEF0);

    // Restart from HALT with a same-cycle rewrite of the start word
    prog_we = 1'b1; prog_addr = 8'd0; prog_wdata = 16'hAAAA;
    issue("restart", 1'b1, 8'd0, 1'b0, 8'd0, 16'hAAAA);
    chk("restart.count", 32'(fetch_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
